// File: rtl/cc_psr_pkg.sv
// Shared types and constants for the PSR flag register.
// Condition codes, PSR bit positions, CC-setting ALU selection range.
package cc_psr_pkg;

    localparam logic [3:0] COND_BN   = 4'b0000;
    localparam logic [3:0] COND_BE   = 4'b0001;
    localparam logic [3:0] COND_BLE  = 4'b0010;
    localparam logic [3:0] COND_BL   = 4'b0011;
    localparam logic [3:0] COND_BLEU = 4'b0100;
    localparam logic [3:0] COND_BCS  = 4'b0101;
    localparam logic [3:0] COND_BNEG = 4'b0110;
    localparam logic [3:0] COND_BVS  = 4'b0111;
    localparam logic [3:0] COND_BA   = 4'b1000;
    localparam logic [3:0] COND_BNE  = 4'b1001;
    localparam logic [3:0] COND_BG   = 4'b1010;
    localparam logic [3:0] COND_BGE  = 4'b1011;
    localparam logic [3:0] COND_BGU  = 4'b1100;
    localparam logic [3:0] COND_BCC  = 4'b1101;
    localparam logic [3:0] COND_BPOS = 4'b1110;
    localparam logic [3:0] COND_BVC  = 4'b1111;

    localparam int PSR_N_BIT = 23;
    localparam int PSR_Z_BIT = 22;
    localparam int PSR_V_BIT = 21;
    localparam int PSR_C_BIT = 20;

    localparam logic [3:0] ALUSEL_CC_FIRST = 4'b0000;
    localparam logic [3:0] ALUSEL_CC_LAST  = 4'b0011;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } psr_flags_t;

endpackage

// File: rtl/cc_cond_eval.sv
// Combinational branch-condition evaluator.
// Ports: cond (4-bit code), n/z/v/c flags in; taken out.
module cc_cond_eval
    import cc_psr_pkg::*;
(
    input  logic [3:0] cond,
    input  logic       n,
    input  logic       z,
    input  logic       v,
    input  logic       c,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        unique case (cond)
            COND_BN:   taken = 1'b0;
            COND_BE:   taken = z;
            COND_BLE:  taken = z | (n ^ v);
            COND_BL:   taken = n ^ v;
            COND_BLEU: taken = c | z;
            COND_BCS:  taken = c;
            COND_BNEG: taken = n;
            COND_BVS:  taken = v;
            COND_BA:   taken = 1'b1;
            COND_BNE:  taken = ~z;
            COND_BG:   taken = ~(z | (n ^ v));
            COND_BGE:  taken = ~(n ^ v);
            COND_BGU:  taken = ~(c | z);
            COND_BCC:  taken = ~c;
            COND_BPOS: taken = ~n;
            COND_BVC:  taken = ~v;
        endcase
    end

endmodule

// File: rtl/cc_psr_flags.sv
// PSR icc register: captures ALU flags, save/restore over the bus,
// registered branch-condition response. Macro: CC_PSR_FORWARD_EN.
module cc_psr_flags
    import cc_psr_pkg::*;
#(
    parameter int DATAWIDTH_BUS           = 32,
    parameter int DATAWIDTH_ALU_SELECTION = 4,
    parameter int DATAWIDTH_COND          = 4
)(
    input  logic                               CC_PSR_CLOCK_50,
    input  logic                               CC_PSR_RESET_InLow,
    input  logic                               CC_PSR_Negative_InHigh,
    input  logic                               CC_PSR_Zero_InHigh,
    input  logic                               CC_PSR_Overflow_InHigh,
    input  logic                               CC_PSR_Carry_InHigh,
    input  logic [DATAWIDTH_ALU_SELECTION-1:0] CC_PSR_ALUSelection_In,
    input  logic                               CC_PSR_Load_InHigh,
    input  logic                               CC_PSR_WritePSR_InHigh,
    input  logic [DATAWIDTH_BUS-1:0]           CC_PSR_DataBUS_In,
    input  logic [DATAWIDTH_COND-1:0]          CC_PSR_Cond_In,
    input  logic                               CC_PSR_CondValid_InHigh,
    output logic                               CC_PSR_Negative_OutHigh,
    output logic                               CC_PSR_Zero_OutHigh,
    output logic                               CC_PSR_Overflow_OutHigh,
    output logic                               CC_PSR_Carry_OutHigh,
    output logic [DATAWIDTH_BUS-1:0]           CC_PSR_DataBUS_Out,
    output logic                               CC_PSR_BranchValid_OutHigh,
    output logic                               CC_PSR_BranchTaken_OutHigh
);

    localparam int SW = DATAWIDTH_ALU_SELECTION;

    psr_flags_t flags_q, flags_d, eval_flags;
    logic       valid_q, valid_d;
    logic       taken_q, taken_d;
    logic       taken;
    logic       cc_sel;
    logic [SW-1:0] sel_off;
    logic       unused_bus;

    // Offset compare avoids a constant-true test when the range starts at 0.
    assign sel_off = CC_PSR_ALUSelection_In - SW'(ALUSEL_CC_FIRST);
    assign cc_sel  = sel_off <= SW'(ALUSEL_CC_LAST - ALUSEL_CC_FIRST);

    assign unused_bus = ^{CC_PSR_DataBUS_In[DATAWIDTH_BUS-1:PSR_N_BIT+1],
                          CC_PSR_DataBUS_In[PSR_C_BIT-1:0]};

    always_comb begin
        flags_d = flags_q;
        if (CC_PSR_WritePSR_InHigh) begin
            flags_d.n = CC_PSR_DataBUS_In[PSR_N_BIT];
            flags_d.z = CC_PSR_DataBUS_In[PSR_Z_BIT];
            flags_d.v = CC_PSR_DataBUS_In[PSR_V_BIT];
            flags_d.c = CC_PSR_DataBUS_In[PSR_C_BIT];
        end else if (CC_PSR_Load_InHigh && cc_sel) begin
            flags_d.n = CC_PSR_Negative_InHigh;
            flags_d.z = CC_PSR_Zero_InHigh;
            flags_d.v = CC_PSR_Overflow_InHigh;
            flags_d.c = CC_PSR_Carry_InHigh;
        end
    end

`ifdef CC_PSR_FORWARD_EN
    // Next-state flags already follow restore-over-capture priority.
    assign eval_flags = flags_d;
`else
    assign eval_flags = flags_q;
`endif

    cc_cond_eval u_eval (
        .cond  (CC_PSR_Cond_In[3:0]),
        .n     (eval_flags.n),
        .z     (eval_flags.z),
        .v     (eval_flags.v),
        .c     (eval_flags.c),
        .taken (taken)
    );

    always_comb begin
        valid_d = CC_PSR_CondValid_InHigh;
        taken_d = CC_PSR_CondValid_InHigh ? taken : taken_q;
    end

    always_ff @(posedge CC_PSR_CLOCK_50 or negedge CC_PSR_RESET_InLow) begin
        if (!CC_PSR_RESET_InLow) begin
            flags_q <= '0;
            valid_q <= 1'b0;
            taken_q <= 1'b0;
        end else begin
            flags_q <= flags_d;
            valid_q <= valid_d;
            taken_q <= taken_d;
        end
    end

    always_comb begin
        CC_PSR_DataBUS_Out            = '0;
        CC_PSR_DataBUS_Out[PSR_N_BIT] = flags_q.n;
        CC_PSR_DataBUS_Out[PSR_Z_BIT] = flags_q.z;
        CC_PSR_DataBUS_Out[PSR_V_BIT] = flags_q.v;
        CC_PSR_DataBUS_Out[PSR_C_BIT] = flags_q.c;
    end

    assign CC_PSR_Negative_OutHigh    = flags_q.n;
    assign CC_PSR_Zero_OutHigh        = flags_q.z;
    assign CC_PSR_Overflow_OutHigh    = flags_q.v;
    assign CC_PSR_Carry_OutHigh       = flags_q.c;
    assign CC_PSR_BranchValid_OutHigh = valid_q;
    assign CC_PSR_BranchTaken_OutHigh = taken_q;

endmodule

// File: tb/tb_cc_psr_flags.sv
// Bench for cc_psr_flags: vector table plus scoreboard queue.
// Reset-during-evaluation handled as a hand-written sequence.
module tb_cc_psr_flags;

`ifdef CC_PSR_FORWARD_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        n_in = 0, z_in = 0, v_in = 0, c_in = 0;
    logic [3:0]  sel = '0;
    logic        load = 0, wr = 0, cv = 0;
    logic [31:0] din = '0;
    logic [3:0]  cond = '0;
    logic        n_o, z_o, v_o, c_o, bv, bt;
    logic [31:0] bus;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cc_psr_flags dut (
        .CC_PSR_CLOCK_50            (clk),
        .CC_PSR_RESET_InLow         (rst_n),
        .CC_PSR_Negative_InHigh     (n_in),
        .CC_PSR_Zero_InHigh         (z_in),
        .CC_PSR_Overflow_InHigh     (v_in),
        .CC_PSR_Carry_InHigh        (c_in),
        .CC_PSR_ALUSelection_In     (sel),
        .CC_PSR_Load_InHigh         (load),
        .CC_PSR_WritePSR_InHigh     (wr),
        .CC_PSR_DataBUS_In          (din),
        .CC_PSR_Cond_In             (cond),
        .CC_PSR_CondValid_InHigh    (cv),
        .CC_PSR_Negative_OutHigh    (n_o),
        .CC_PSR_Zero_OutHigh        (z_o),
        .CC_PSR_Overflow_OutHigh    (v_o),
        .CC_PSR_Carry_OutHigh       (c_o),
        .CC_PSR_DataBUS_Out         (bus),
        .CC_PSR_BranchValid_OutHigh (bv),
        .CC_PSR_BranchTaken_OutHigh (bt)
    );

    typedef struct {
        string       name;
        logic [3:0]  nzvc;
        logic [3:0]  sel;
        logic        load;
        logic        wr;
        logic [31:0] din;
        logic [3:0]  cond;
        logic        cv;
        logic [31:0] e_bus;
        logic        e_bv;
        logic        e_bt;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] bus;
        logic        bv;
        logic        bt;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    function automatic vec_t mk(string nm, logic [3:0] nzvc,
                                logic [3:0] s, logic ld, logic w,
                                logic [31:0] d, logic [3:0] cd,
                                logic vl, logic [31:0] eb,
                                logic ev, logic et);
        vec_t r;
        r.name = nm; r.nzvc = nzvc; r.sel = s; r.load = ld;
        r.wr = w; r.din = d; r.cond = cd; r.cv = vl;
        r.e_bus = eb; r.e_bv = ev; r.e_bt = et;
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_outputs(exp_t e);
        chk({e.name, " bus"}, bus, e.bus);
        chk({e.name, " flags"}, {28'd0, n_o, z_o, v_o, c_o},
            {28'd0, e.bus[23:20]});
        chk({e.name, " valid"}, {31'd0, bv}, {31'd0, e.bv});
        chk({e.name, " taken"}, {31'd0, bt}, {31'd0, e.bt});
    endtask

    task automatic step(vec_t t);
        exp_t e;
        @(negedge clk);
        {n_in, z_in, v_in, c_in} = t.nzvc;
        sel = t.sel; load = t.load; wr = t.wr; din = t.din;
        cond = t.cond; cv = t.cv;
        e.name = t.name; e.bus = t.e_bus; e.bv = t.e_bv; e.bt = t.e_bt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: empty queue at %s", t.name);
        end else begin
            check_outputs(sb.pop_front());
        end
    endtask

    localparam logic [15:0] SWEEP = 16'b1000_0011_0111_1100;

    initial begin
        exp_t e0;
        #12;
        e0.name = "reset"; e0.bus = '0; e0.bv = 0; e0.bt = 0;
        check_outputs(e0);
        @(negedge clk);
        rst_n = 1'b1;

        tbl.push_back(mk("ba_after_rst", 4'h0, 4'h0, 0, 0, 0, 4'h8, 1,
                         32'h0, 1, 1));
        tbl.push_back(mk("cap_addcc", 4'b1010, 4'h3, 1, 0, 0, 4'h0, 0,
                         32'h00A00000, 0, 1));
        tbl.push_back(mk("sel_filter", 4'b1111, 4'h8, 1, 0, 0, 4'h0, 0,
                         32'h00A00000, 0, 1));
        tbl.push_back(mk("load_low", 4'b1111, 4'h1, 0, 0, 0, 4'h0, 0,
                         32'h00A00000, 0, 1));
        tbl.push_back(mk("wr_prio", 4'b1000, 4'h0, 1, 1, 32'h00500000,
                         4'h0, 0, 32'h00500000, 0, 1));
        tbl.push_back(mk("wr_nc", 4'h0, 4'h0, 0, 1, 32'hFF9FFFFF,
                         4'h0, 0, 32'h00900000, 0, 1));
        for (int i = 0; i < 16; i++)
            tbl.push_back(mk($sformatf("sweep%0d", i), 4'h0, 4'h0, 0, 0,
                             0, 4'(i), 1, 32'h00900000, 1, SWEEP[i]));
        tbl.push_back(mk("idle_hold", 4'h0, 4'h0, 0, 0, 0, 4'h0, 0,
                         32'h00900000, 0, 1));
        tbl.push_back(mk("clr_flags", 4'h0, 4'h0, 0, 1, 32'h0, 4'h0, 0,
                         32'h0, 0, 1));
        tbl.push_back(mk("hazard", 4'b0100, 4'h3, 1, 0, 0, 4'h1, 1,
                         32'h00400000, 1, FWD));
        tbl.push_back(mk("hazard_hold", 4'h0, 4'h0, 0, 0, 0, 4'h0, 0,
                         32'h00400000, 0, FWD));
        tbl.push_back(mk("be_after", 4'h0, 4'h0, 0, 0, 0, 4'h1, 1,
                         32'h00400000, 1, 1));
        tbl.push_back(mk("bne_after", 4'h0, 4'h0, 0, 0, 0, 4'h9, 1,
                         32'h00400000, 1, 0));
        tbl.push_back(mk("fwd_wr", 4'h0, 4'h0, 0, 1, 32'h00100000, 4'h5,
                         1, 32'h00100000, 1, FWD));
        tbl.push_back(mk("bne_hold0", 4'h0, 4'h0, 0, 0, 0, 4'h9, 1,
                         32'h00100000, 1, 1));

        foreach (tbl[i]) step(tbl[i]);

        // Reset while a response is pending and a capture is requested.
        @(negedge clk);
        cond = 4'h8; cv = 1;
        @(posedge clk);
        #1;
        chk("pre_rst valid", {31'd0, bv}, 32'd1);
        rst_n = 1'b0;
        load = 1; sel = 4'h3; {n_in, z_in, v_in, c_in} = 4'hF;
        #2;
        e0.name = "mid_rst";
        check_outputs(e0);
        @(posedge clk);
        #1;
        e0.name = "in_rst";
        check_outputs(e0);
        @(negedge clk);
        rst_n = 1'b1;
        load = 0; cv = 0;
        step(mk("post_rst", 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 32'h0, 0, 0));
        step(mk("post_rst_ba", 4'h0, 4'h0, 0, 0, 0, 4'h8, 1, 32'h0, 1, 1));

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d left over", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cc_psr_flags.md
Name: cc_psr_flags

Overview:
- Receiving end of the ALU flag interface: a processor-status register that captures N/Z/V/C from the ALU on condition-code-setting operations.
- Evaluates 4-bit branch conditions against the captured flags and returns a registered taken/not-taken response to the microsequencer.
- Supports save/restore of the icc field over the 32-bit data bus for trap entry/exit.
- Sits between the ALU flag outputs and the control unit, alongside the register file in the micro datapath.

Parameters:
- DATAWIDTH_BUS, 32: data bus width for PSR read/write.
- DATAWIDTH_ALU_SELECTION, 4: ALU operation select width.
- DATAWIDTH_COND, 4: branch condition field width.

Ports:
- CC_PSR_CLOCK_50  input  1  system clock, rising edge.
- CC_PSR_RESET_InLow  input  1  asynchronous, active-low reset.
- CC_PSR_Negative_InHigh  input  1  ALU N flag.
- CC_PSR_Zero_InHigh  input  1  ALU Z flag.
- CC_PSR_Overflow_InHigh  input  1  ALU V flag.
- CC_PSR_Carry_InHigh  input  1  ALU C flag.
- CC_PSR_ALUSelection_In  input  DATAWIDTH_ALU_SELECTION  ALU operation currently executing.
- CC_PSR_Load_InHigh  input  1  ALU result valid this cycle; qualifies flag capture.
- CC_PSR_WritePSR_InHigh  input  1  restore icc from the data bus.
- CC_PSR_DataBUS_In  input  DATAWIDTH_BUS  restore data.
- CC_PSR_Cond_In  input  DATAWIDTH_COND  branch condition code.
- CC_PSR_CondValid_InHigh  input  1  evaluation request.
- CC_PSR_Negative_OutHigh, CC_PSR_Zero_OutHigh, CC_PSR_Overflow_OutHigh, CC_PSR_Carry_OutHigh  output  1 each  registered flags.
- CC_PSR_DataBUS_Out  output  DATAWIDTH_BUS  PSR image: N at bit 23, Z at 22, V at 21, C at 20; all other bits 0.
- CC_PSR_BranchValid_OutHigh  output  1  response strobe.
- CC_PSR_BranchTaken_OutHigh  output  1  condition result; meaningful only while BranchValid is 1.

Behaviour:
- Interface: one clock, CC_PSR_CLOCK_50. Reset CC_PSR_RESET_InLow is asynchronous and active-low.
- Reset: all four flags 0, BranchValid 0, BranchTaken 0, DataBUS_Out 0. Asserting reset mid-evaluation drops any pending response; no BranchValid pulse follows.
- Flag capture: flags load on a clock edge when Load=1 and ALUSelection is in 4'b0000..4'b0011 (ANDCC, ORCC, NORCC, ADDCC). Any other selection, or Load=0, holds the flags.
- Restore: WritePSR=1 loads N/Z/V/C from DataBUS_In[23:20] on the next edge. WritePSR has priority over a simultaneous flag capture.
- DataBUS_Out: combinational from the registered flags; reflects a write one cycle after the edge.
- Evaluation: a request with CondValid=1 at edge k produces BranchValid=1 and BranchTaken for one cycle after edge k.
  - Latency is 1 cycle; back-to-back requests every cycle are allowed, with no stall and no backpressure.
  - BranchValid is 0 in any cycle without a request one cycle earlier.
  - BranchTaken holds its last value while BranchValid=0.
- Condition encoding:
  - 0000 never; 0001 Z; 0010 Z|(N^V); 0011 N^V.
  - 0100 C|Z; 0101 C; 0110 N; 0111 V.
  - 1000 always; 1001 ~Z; 1010 ~(Z|(N^V)); 1011 ~(N^V).
  - 1100 ~(C|Z); 1101 ~C; 1110 ~N; 1111 ~V.
- Simultaneous capture/restore and evaluation in the same cycle: evaluation uses the flags held before that edge, unless the forwarding feature below is compiled in.

Optional Feature:
- Macro: CC_PSR_FORWARD_EN.
- Defined: an evaluation in the same cycle as a qualifying capture (or restore) uses the incoming flags (or DataBUS_In[23:20]), following the same priority as the flag register. This removes the one-instruction flag hazard.
- Undefined: evaluation always uses the registered flags, and the control unit inserts one bubble after a CC-setting operation.

Decomposition:
- Shared package cc_psr_pkg holds:
  - condition-code constants (COND_BN … COND_BVC);
  - PSR bit positions PSR_N_BIT=23, PSR_Z_BIT=22, PSR_V_BIT=21, PSR_C_BIT=20;
  - CC-setting selection bounds ALUSEL_CC_FIRST=4'b0000 and ALUSEL_CC_LAST=4'b0011.
- One combinational sub-module, cc_cond_eval: inputs cond, N, Z, V, C; output taken. Instantiated once, with its flag inputs muxed by the forwarding option.

Test Plan:
- Reset: hold RESET_InLow=0 mid-traffic -> all flags 0, DataBUS_Out=32'h0, BranchValid=0. Release, then Cond=1000 with CondValid -> BranchTaken=1 one cycle later.
- Capture filter:
  - Load=1, Sel=0011, flags N=1,Z=0,V=1,C=0 -> DataBUS_Out=32'h00A00000.
  - Then Load=1, Sel=1000 with all flags 1 -> unchanged 32'h00A00000.
  - Then Load=0, Sel=0001 with all flags 1 -> unchanged 32'h00A00000.
- Priority: WritePSR=1 with DataBUS_In=32'h00500000, plus a simultaneous capture of N=1,Z=0,V=0,C=0 -> flags Z=1,C=1, DataBUS_Out=32'h00500000.
- Condition sweep: with flags N=1,Z=0,V=0,C=1, issue all 16 conds back-to-back -> BranchValid high for 16 consecutive cycles. BranchTaken sequence: 0,0,1,1,1,1,1,0,1,1,0,0,0,0,0,1.
- Hazard: flags Z=0, then same cycle capture Z=1 and eval Cond=0001 -> BranchTaken=0 without CC_PSR_FORWARD_EN, 1 with it.
